btn_debounce: RTL and testbench

//  Front end between raw board push-buttons and the LED_RGB control logic.
//  Per button: 2-FF synchroniser, then a debounce counter and a 4-state FSM.

---
 rtl/btn_pkg.sv | 10 +
 rtl/btn_debounce_if.sv | 9 +
 rtl/btn_debounce_ch.sv | 73 +++++++
 rtl/btn_debounce.sv | 23 ++
 tb/tb_btn_debounce.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared debounce FSM state encoding and the short bench debounce length
package btn_pkg;
  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } state_t;
  localparam int DEB_CYCLES_SIM = 16;
endpackage

// File: rtl/btn_debounce_if.sv
// btn_debounce_if: raw button inputs and the debounced level/strobe outputs
interface btn_debounce_if #(parameter int N_BTN = 3);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  modport master (output btn_raw, input btn_level, btn_press, btn_release);
  modport slave (input btn_raw, output btn_level, btn_press, btn_release);
endinterface

// File: rtl/btn_debounce_ch.sv
// debounce_ch: one button channel, 2-FF synchroniser feeding a counted 4-state debounce FSM
module debounce_ch
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES = 1_250_000,
  parameter int CNT_W      = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rls
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEB_CYCLES - 1);
  state_t st_q, st_d;
  logic s1_q, s1_d, s2_q, s2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic level_q, level_d, press_q, press_d, rls_q, rls_d;
  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    st_d    = st_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rls_d   = 1'b0;
    case (st_q)
      S_LOW: if (s2_q) begin
        st_d  = S_RISE;
        cnt_d = '0;
      end
      S_RISE: if (!s2_q) st_d = S_LOW;
      else if (cnt_q == LAST) begin
        st_d    = S_HIGH;
        level_d = 1'b1;
        press_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
      S_HIGH: if (!s2_q) begin
        st_d  = S_FALL;
        cnt_d = '0;
      end
      default: if (s2_q) st_d = S_HIGH;
      else if (cnt_q == LAST) begin
        st_d    = S_LOW;
        level_d = 1'b0;
        rls_d   = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      st_q    <= S_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rls_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rls_q   <= rls_d;
    end
  end
  assign level = level_q;
  assign press = press_q;
  assign rls   = rls_q;
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: N_BTN independent debounce channels behind one interface
module btn_debounce
  import btn_pkg::*;
#(
  parameter int N_BTN      = 3,
  parameter int DEB_CYCLES = 1_250_000,
  parameter int CNT_W      = 21
) (
  input logic           clk,
  input logic           rst,
  btn_debounce_if.slave bus
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_ch #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_ch (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.btn_raw[i]),
      .level (bus.btn_level[i]),
      .press (bus.btn_press[i]),
      .rls   (bus.btn_release[i])
    );
  end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed + random stimulus, run-length reference model, queued scoreboard
module tb_btn_debounce;
  import btn_pkg::*;
  localparam int N = 3;
  localparam int D = DEB_CYCLES_SIM;
  localparam int W = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  btn_debounce_if #(.N_BTN(N)) bus ();
  btn_debounce #(.N_BTN(N), .DEB_CYCLES(D), .CNT_W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );
  logic [3*N-1:0] exp_q[$];
  logic [N-1:0]   hist[$];
  logic [N-1:0]   m_lvl = '0;
  int run[N];
  int presses[N];
  int releases[N];
  int total = 0;
  int bad = 0;
  // Reference: the FSM samples raw two edges late; a level is accepted once
  // D+1 consecutive late samples disagree with the current accepted level.
  initial forever begin
    logic [N-1:0] seen, pr, rl;
    @(posedge clk);
    pr = '0;
    rl = '0;
    if (!rst) begin
      hist.delete();
      m_lvl = '0;
      for (int i = 0; i < N; i++) run[i] = 0;
    end else begin
      seen = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
      hist.push_back(bus.btn_raw);
      if (hist.size() > 2) void'(hist.pop_front());
      for (int i = 0; i < N; i++) begin
        run[i] = (seen[i] != m_lvl[i]) ? run[i] + 1 : 0;
        if (run[i] == D + 1) begin
          m_lvl[i] = ~m_lvl[i];
          pr[i] = m_lvl[i];
          rl[i] = ~m_lvl[i];
          run[i] = 0;
        end
      end
    end
    exp_q.push_back({m_lvl, pr, rl});
  end
  initial forever begin
    logic [3*N-1:0] e, g;
    @(posedge clk);
    #1;
    g = {bus.btn_level, bus.btn_press, bus.btn_release};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL sb_empty t=%0t got=%b need=<queued value>", $time, g);
    end else begin
      e = exp_q.pop_front();
      if (g !== e)
        begin
          bad++;
          $display("FAIL sb_cycle t=%0t got lvl=%b prs=%b rel=%b need lvl=%b prs=%b rel=%b",
                   $time, g[3*N-1:2*N], g[2*N-1:N], g[N-1:0], e[3*N-1:2*N], e[2*N-1:N], e[N-1:0]);
        end
    end
    total++;
    if ((bus.btn_press & bus.btn_release) != '0) begin
      bad++;
      $display("FAIL both_strobes t=%0t got prs=%b rel=%b need no overlap", $time, bus.btn_press, bus.btn_release);
    end
    for (int i = 0; i < N; i++) begin
      presses[i] += int'(bus.btn_press[i]);
      releases[i] += int'(bus.btn_release[i]);
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clr();
    for (int i = 0; i < N; i++) begin
      presses[i] = 0;
      releases[i] = 0;
    end
  endtask
  task automatic chk(input string name, input int got, input int need);
    total++;
    if (got != need) begin
      bad++;
      $display("FAIL %s got=%0d need=%0d", name, got, need);
    end
  endtask
  initial begin
    bus.btn_raw = '1;
    cyc(4);
    chk("t1_rst_level", int'(bus.btn_level), 0);
    clr();
    rst = 1'b1;
    cyc(25);
    chk("t1_press0", presses[0], 1);
    chk("t1_press1", presses[1], 1);
    chk("t1_press2", presses[2], 1);
    chk("t1_level", int'(bus.btn_level), 7);
    bus.btn_raw = '0;
    cyc(25);
    chk("t1_release", releases[0] + releases[1] + releases[2], 3);
    clr();
    bus.btn_raw[0] = 1'b1;
    cyc(40);
    chk("t2_level0", int'(bus.btn_level[0]), 1);
    chk("t2_press0", presses[0], 1);
    bus.btn_raw[0] = 1'b0;
    cyc(25);
    chk("t2_release0", releases[0], 1);
    chk("t2_level0_off", int'(bus.btn_level[0]), 0);
    clr();
    for (int k = 0; k < 10; k++) begin
      bus.btn_raw[1] = ~bus.btn_raw[1];
      cyc(3);
    end
    chk("t3_no_bounce_press", presses[1], 0);
    bus.btn_raw[1] = 1'b1;
    cyc(25);
    chk("t3_press1", presses[1], 1);
    bus.btn_raw[1] = 1'b0;
    cyc(25);
    clr();
    bus.btn_raw[2] = 1'b1;
    cyc(10);
    bus.btn_raw[2] = 1'b0;
    cyc(25);
    chk("t4_press2", presses[2], 0);
    chk("t4_release2", releases[2], 0);
    chk("t4_level2", int'(bus.btn_level[2]), 0);
    clr();
    bus.btn_raw = 3'b101;
    cyc(25);
    chk("t5_press0", presses[0], 1);
    chk("t5_press1", presses[1], 0);
    chk("t5_press2", presses[2], 1);
    bus.btn_raw = '0;
    cyc(25);
    clr();
    bus.btn_raw[0] = 1'b1;
    cyc(13);
    rst = 1'b0;
    cyc(3);
    chk("t6_rst_level", int'(bus.btn_level), 0);
    chk("t6_rst_press", presses[0], 0);
    rst = 1'b1;
    cyc(18);
    chk("t6_early_press", presses[0], 0);
    cyc(7);
    chk("t6_press0", presses[0], 1);
    bus.btn_raw = '0;
    cyc(25);
    for (int k = 0; k < 60; k++) begin
      bus.btn_raw = N'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
      end
      cyc($urandom_range(1, 30));
    end
    cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
